// File: rtl/csr_unit_m.sv
`default_nettype none
// ============================================================================
// Module   : csr_unit_m
// Brief    : Machine-mode CSR unit with CSRRW/CSRRS/CSRRC, trap entry and
//            MRET stacking, interrupt enable/pending, direct/vectored
//            trap vectors and free-running cycle/instret counters.
// Revision : 1.0 - initial release
// ============================================================================
module csr_unit_m #(
  parameter int          XLEN        = 32,
  parameter int          COUNTER_W   = 64,
  parameter logic [31:0] MTVEC_RESET = 32'hFFFFFF00,
  parameter bit          VECTORED_EN = 1'b1,
  parameter logic [31:0] HART_ID     = 32'd0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            csr_en_i,
  input  logic [1:0]      csr_op_i,
  input  logic [11:0]     csr_addr_i,
  input  logic [XLEN-1:0] csr_wdata_i,
  output logic [XLEN-1:0] csr_rdata_o,
  output logic            csr_illegal_o,
  input  logic            trap_i,
  input  logic            trap_is_irq_i,
  input  logic [3:0]      trap_cause_i,
  input  logic [XLEN-1:0] trap_pc_i,
  input  logic [XLEN-1:0] trap_tval_i,
  input  logic            mret_i,
  input  logic            instret_i,
  input  logic            irq_ext_i,
  input  logic            irq_timer_i,
  input  logic            irq_sw_i,
  output logic            irq_pending_o,
  output logic [3:0]      irq_cause_o,
  output logic [XLEN-1:0] trap_vector_o,
  output logic [XLEN-1:0] mepc_o
);

  localparam logic [1:0]  OP_RW = 2'b01;
  localparam logic [1:0]  OP_RS = 2'b10;
  localparam logic [1:0]  OP_RC = 2'b11;

  localparam logic [11:0] A_MSTATUS  = 12'h300;
  localparam logic [11:0] A_MISA     = 12'h301;
  localparam logic [11:0] A_MIE      = 12'h304;
  localparam logic [11:0] A_MTVEC    = 12'h305;
  localparam logic [11:0] A_MCNTINH  = 12'h320;
  localparam logic [11:0] A_MSCRATCH = 12'h340;
  localparam logic [11:0] A_MEPC     = 12'h341;
  localparam logic [11:0] A_MCAUSE   = 12'h342;
  localparam logic [11:0] A_MTVAL    = 12'h343;
  localparam logic [11:0] A_MIP      = 12'h344;
  localparam logic [11:0] A_MCYCLE   = 12'hB00;
  localparam logic [11:0] A_MINSTRET = 12'hB02;
  localparam logic [11:0] A_MCYCLEH  = 12'hB80;
  localparam logic [11:0] A_MINSTRH  = 12'hB82;
  localparam logic [11:0] A_MHARTID  = 12'hF14;

  // Architectural state
  logic                 st_mie, st_mpie;
  logic                 msie, mtie, meie;
  logic                 msip, mtip, meip;
  logic                 cy_inhibit, ir_inhibit;
  logic [31:0]          mtvec, mscratch, mepc, mcause, mtval;
  logic [COUNTER_W-1:0] mcycle, minstret;

  // Combinational helpers
  logic [63:0]          mcycle_ext, minstret_ext;
  logic [31:0]          old_val, new_val, mtvec_base;
  logic                 implemented, csr_we;
  logic [2:0]           pend;
  logic [COUNTER_W-1:0] mcycle_next, minstret_next;

  assign mcycle_ext   = 64'(mcycle);
  assign minstret_ext = 64'(minstret);

  // Pre-write read mux; also flags which addresses exist
  always_comb begin
    old_val     = 32'd0;
    implemented = 1'b1;
    case (csr_addr_i)
      A_MSTATUS:  old_val = {19'd0, 2'b11, 3'd0, st_mpie, 3'd0, st_mie, 3'd0};
      A_MISA:     old_val = 32'h40000100;
      A_MIE:      old_val = {20'd0, meie, 3'd0, mtie, 3'd0, msie, 3'd0};
      A_MTVEC:    old_val = mtvec;
      A_MCNTINH:  old_val = {29'd0, ir_inhibit, 1'b0, cy_inhibit};
      A_MSCRATCH: old_val = mscratch;
      A_MEPC:     old_val = mepc;
      A_MCAUSE:   old_val = mcause;
      A_MTVAL:    old_val = mtval;
      A_MIP:      old_val = {20'd0, meip, 3'd0, mtip, 3'd0, msip, 3'd0};
      A_MCYCLE:   old_val = mcycle_ext[31:0];
      A_MCYCLEH:  old_val = mcycle_ext[63:32];
      A_MINSTRET: old_val = minstret_ext[31:0];
      A_MINSTRH:  old_val = minstret_ext[63:32];
      A_MHARTID:  old_val = HART_ID;
      default:    implemented = 1'b0;
    endcase
  end

  // Read-modify-write result for the current operation
  always_comb begin
    new_val = old_val;
    case (csr_op_i)
      OP_RW:   new_val = csr_wdata_i;
      OP_RS:   new_val = old_val | csr_wdata_i;
      OP_RC:   new_val = old_val & ~csr_wdata_i;
      default: new_val = old_val;
    endcase
  end

  // Read-only space (addr[11:10]==11) only tolerates set/clear with zero mask
  assign csr_illegal_o = csr_en_i && (csr_op_i != 2'b00) &&
                         (!implemented ||
                          ((csr_addr_i[11:10] == 2'b11) &&
                           ((csr_op_i == OP_RW) || (csr_wdata_i != 32'd0))));
  assign csr_we      = csr_en_i && (csr_op_i != 2'b00) && !csr_illegal_o &&
                       !trap_i && !mret_i;
  assign csr_rdata_o = old_val;

  // Counter next-state: a write to either half replaces that half and
  // suppresses the increment for the whole counter in that cycle
  always_comb begin
    mcycle_next   = cy_inhibit ? mcycle : mcycle + COUNTER_W'(1);
    minstret_next = (instret_i && !ir_inhibit) ? minstret + COUNTER_W'(1) : minstret;
    if (csr_we && csr_addr_i == A_MCYCLE)
      mcycle_next = COUNTER_W'({mcycle_ext[63:32], new_val});
    if (csr_we && csr_addr_i == A_MCYCLEH)
      mcycle_next = COUNTER_W'({new_val, mcycle_ext[31:0]});
    if (csr_we && csr_addr_i == A_MINSTRET)
      minstret_next = COUNTER_W'({minstret_ext[63:32], new_val});
    if (csr_we && csr_addr_i == A_MINSTRH)
      minstret_next = COUNTER_W'({new_val, minstret_ext[31:0]});
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      mcycle   <= '0;
      minstret <= '0;
    end else begin
      mcycle   <= mcycle_next;
      minstret <= minstret_next;
    end
  end

  // Interrupt lines registered once into mip
  always_ff @(posedge clk) begin
    if (rst) begin
      msip <= 1'b0;
      mtip <= 1'b0;
      meip <= 1'b0;
    end else begin
      msip <= irq_sw_i;
      mtip <= irq_timer_i;
      meip <= irq_ext_i;
    end
  end

  // Trap entry, MRET and CSR writes in decreasing priority
  always_ff @(posedge clk) begin
    if (rst) begin
      st_mie     <= 1'b0;
      st_mpie    <= 1'b0;
      msie       <= 1'b0;
      mtie       <= 1'b0;
      meie       <= 1'b0;
      mtvec      <= MTVEC_RESET;
      cy_inhibit <= 1'b0;
      ir_inhibit <= 1'b0;
      mscratch   <= 32'd0;
      mepc       <= 32'd0;
      mcause     <= 32'd0;
      mtval      <= 32'd0;
    end else if (trap_i) begin
      mepc    <= trap_pc_i & ~32'd3;
      mcause  <= {trap_is_irq_i, 27'd0, trap_cause_i};
      mtval   <= trap_tval_i;
      st_mpie <= st_mie;
      st_mie  <= 1'b0;
    end else if (mret_i) begin
      st_mie  <= st_mpie;
      st_mpie <= 1'b1;
    end else if (csr_we) begin
      case (csr_addr_i)
        A_MSTATUS: begin
          st_mie  <= new_val[3];
          st_mpie <= new_val[7];
        end
        A_MIE: begin
          msie <= new_val[3];
          mtie <= new_val[7];
          meie <= new_val[11];
        end
        A_MTVEC:    mtvec <= {new_val[31:2], 1'b0, new_val[0] & VECTORED_EN};
        A_MCNTINH: begin
          cy_inhibit <= new_val[0];
          ir_inhibit <= new_val[2];
        end
        A_MSCRATCH: mscratch <= new_val;
        A_MEPC:     mepc     <= {new_val[31:2], 2'b00};
        A_MCAUSE:   mcause   <= new_val;
        A_MTVAL:    mtval    <= new_val;
        default:    ;
      endcase
    end
  end

  // Enabled-and-pending interrupts, gated by global MIE
  assign pend = {meip & meie, mtip & mtie, msip & msie} & {3{st_mie}};

  assign irq_pending_o = !rst && (|pend);
  assign irq_cause_o   = pend[2] ? 4'd11 : pend[0] ? 4'd3 : pend[1] ? 4'd7 : 4'd0;

  assign mtvec_base    = {mtvec[31:2], 2'b00};
  assign trap_vector_o = rst ? (MTVEC_RESET & ~32'd3) :
                         (mtvec[0] && trap_is_irq_i) ?
                           mtvec_base + {26'd0, trap_cause_i, 2'b00} : mtvec_base;
  assign mepc_o        = rst ? 32'd0 : mepc;

endmodule
`default_nettype wire
